dfr_axi_lite_master: RTL and testbench
======================================

# dfr_axi_lite_master

Hardware AXI4-Lite initiator that issues single-beat register and memory transactions to the DFR core's slave port (`dfr_core_top`), replacing software/bench-driven configuration. A simple command/response interface on one side is converted into compliant AW/W/B and AR/R channel handshakes on the other. One transaction is outstanding at a time, and a per-transaction timeout guards against a hung slave. It sits between an on-chip sequencer (or debug UART bridge) and the DFR core's AXI slave port.

## Interface
- `C_M_AXI_ADDR_WIDTH`, 30, AXI address width (matches DFR core slave)
- `C_M_AXI_DATA_WIDTH`, 32, AXI data width; WSTRB width = `C_M_AXI_DATA_WIDTH/8`
- `TIMEOUT_CYCLES`, 1024, max cycles from command accept to completion; 0 disables timeout
- `M_AXI_ACLK` in 1: single clock; all logic rising-edge
- `M_AXI_ARESET` in 1: reset, asynchronous, active-high
- `cmd_valid` in 1: command request
- `cmd_ready` out 1: command accepted when both high
- `cmd_write` in 1: 1 = write, 0 = read
- `cmd_addr` in ADDR: byte address
- `cmd_wdata` in DATA: write data (ignored for reads)
- `rsp_valid` out 1: response available; held until taken
- `rsp_ready` in 1: response consumed when both high
- `rsp_write` out 1: echoes `cmd_write` of completed transaction
- `rsp_rdata` out DATA: read data; 0 for writes and timeouts
- `rsp_resp` out 2: BRESP/RRESP from slave; 2'b10 on timeout
- `rsp_timeout` out 1: transaction aborted by timeout
- `busy` out 1: high whenever state != IDLE
- `M_AXI_AWADDR` out ADDR, `M_AXI_AWVALID` out 1, `M_AXI_AWREADY` in 1
- `M_AXI_WDATA` out DATA, `M_AXI_WSTRB` out DATA/8, `M_AXI_WVALID` out 1, `M_AXI_WREADY` in 1
- `M_AXI_BRESP` in 2, `M_AXI_BVALID` in 1, `M_AXI_BREADY` out 1
- `M_AXI_ARADDR` out ADDR, `M_AXI_ARVALID` out 1, `M_AXI_ARREADY` in 1
- `M_AXI_RDATA` in DATA, `M_AXI_RRESP` in 2, `M_AXI_RVALID` in 1, `M_AXI_RREADY` out 1

## Operation
- **States:** IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP.
- **IDLE:**
  - `cmd_ready` = 1.
  - On accept, latch addr/wdata/write. Go to WR_REQ if write, RD_REQ if read.
  - Clear the timeout counter.
- **WR_REQ:**
  - AWVALID and WVALID rise together. Each drops independently after its own handshake, tracked by `aw_done`/`w_done` flags.
  - AWREADY and WREADY may arrive in either order or in the same cycle.
  - When both flags are set, go to WR_RESP.
- **WR_RESP:**
  - BREADY = 1.
  - On BVALID, capture BRESP, set `rsp_rdata` = 0, go to RESP.
- **RD_REQ:**
  - ARVALID = 1 until ARREADY, then go to RD_RESP.
- **RD_RESP:**
  - RREADY = 1.
  - On RVALID, capture RDATA and RRESP, go to RESP.
- **RESP:**
  - `rsp_valid` = 1.
  - On `rsp_ready`, go to IDLE.
  - A new command is never accepted while a response is pending.
- **Fixed outputs:** WSTRB is always all-ones. AWADDR, ARADDR and WDATA are stable while their VALID is high.
- **Timeout:**
  - The counter increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - When it reaches TIMEOUT_CYCLES, all VALID/READY outputs drop the next cycle. The block then goes to RESP with `rsp_timeout` = 1, `rsp_resp` = 2'b10, `rsp_rdata` = 0.
  - A later BVALID/RVALID from the slave is not consumed. Recovery requires a reset.
- **Reset:**
  - All outputs are 0 (including `cmd_ready`), state is IDLE, counters and flags are cleared.
  - `cmd_ready` rises the first cycle after reset deasserts.
  - Reset mid-transaction drops all VALID/READY immediately (asynchronously).

## Timing
- All AXI outputs and `rsp_*` are registered; no combinational path from AXI inputs to AXI outputs.
- **Write, zero-wait slave:**
  - Cycle 0: accept.
  - Cycle 1: AW/W VALID high, handshake.
  - Cycle 2: BREADY high; BVALID seen.
  - Cycle 3: `rsp_valid`. Minimum write latency is 3 cycles.
- **Read, zero-wait slave:** ARVALID in cycle 1, RREADY in cycle 2, `rsp_valid` in cycle 3.
- A VALID is never deasserted before its handshake except on timeout or reset.
- With `rsp_ready` tied high, RESP lasts 1 cycle. Back-to-back command throughput is 1 transaction per 4 cycles minimum.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`. The comparison is equality, so there is no wrap-around.

## Structure
- **Shared package `dfr_axi_pkg`:**
  - State enum `axi_mst_state_t`.
  - Response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - DFR register addresses 0x0000–0x0020 (CTRL, DEBUG, NUM_*).
  - Memory offsets 0x0100_0000 (input), 0x0200_0000 (reservoir), 0x0300_0000 (weight), 0x0400_0000 (output).
- Single module; no sub-module. The timeout counter is small enough to stay inline.

## Test plan
- **Write, zero-wait slave:** write 0x0000_0064 to 0x0014 → AWADDR = 0x0014, WDATA = 0x64, WSTRB = 0xF; `rsp_valid` at cycle 3 with `rsp_resp` = 00, `rsp_write` = 1.
- **Skewed write readies:** AWREADY 3 cycles before WREADY → AWVALID drops after its handshake, WVALID holds until WREADY; exactly one B handshake, `rsp_resp` = 00.
- **Read after write:** write 300 to 0x0100_0004, then read it back → `rsp_rdata` = 300 (0x12C), `rsp_write` = 0; `cmd_ready` low from accept through response take.
- **Timeout:** TIMEOUT_CYCLES = 16, slave never asserts ARREADY → ARVALID drops after 16 cycles; `rsp_timeout` = 1, `rsp_resp` = 10, `rsp_rdata` = 0.
- **Response backpressure:** hold `rsp_ready` low 10 cycles → `rsp_*` stable; `cmd_ready` stays 0 and a pending `cmd_valid` is not accepted.
- **Reset mid-write:** assert reset while AWVALID = 1 → all AXI VALID/READY = 0 immediately, `busy` = 0; after release, a new read to 0x0000 completes normally.

Source files
------------

// File: rtl/dfr_axi_pkg.sv
// Shared definitions for the DFR AXI4-Lite master: FSM encoding, response codes
// and the DFR core register/memory map.
package dfr_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RESP
  } axi_mst_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // DFR core control/configuration registers
  localparam logic [31:0] DFR_REG_CTRL        = 32'h0000_0000;
  localparam logic [31:0] DFR_REG_DEBUG       = 32'h0000_0004;
  localparam logic [31:0] DFR_REG_NUM_INPUTS  = 32'h0000_0008;
  localparam logic [31:0] DFR_REG_NUM_NODES   = 32'h0000_000C;
  localparam logic [31:0] DFR_REG_NUM_OUTPUTS = 32'h0000_0010;
  localparam logic [31:0] DFR_REG_NUM_STEPS   = 32'h0000_0014;
  localparam logic [31:0] DFR_REG_NUM_TAPS    = 32'h0000_0018;
  localparam logic [31:0] DFR_REG_NUM_WEIGHTS = 32'h0000_001C;
  localparam logic [31:0] DFR_REG_NUM_EPOCHS  = 32'h0000_0020;

  // DFR core memory windows
  localparam logic [31:0] DFR_MEM_INPUT     = 32'h0100_0000;
  localparam logic [31:0] DFR_MEM_RESERVOIR = 32'h0200_0000;
  localparam logic [31:0] DFR_MEM_WEIGHT    = 32'h0300_0000;
  localparam logic [31:0] DFR_MEM_OUTPUT    = 32'h0400_0000;

endpackage

// File: rtl/dfr_axi_lite_master.sv
// AXI4-Lite single-beat initiator: converts a command/response interface into
// AW/W/B and AR/R handshakes, one transaction in flight, with a hang timeout.
module dfr_axi_lite_master
  import dfr_axi_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 30,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_timeout,
  output logic                              busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int unsigned CW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TO_M1 = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TO_LIM = CW'(TO_M1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  axi_mst_state_t state, state_n;
  logic [CW-1:0] to_cnt, to_cnt_n;
  logic aw_done, aw_done_n, w_done, w_done_n;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_n, rsp_rdata_n;
  logic write_q, write_n;
  logic [1:0] rsp_resp_n;
  logic rsp_timeout_n, cmd_ready_n, rsp_valid_n, busy_n;
  logic awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, timed_out;

  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID  & M_AXI_WREADY;
  assign b_hs  = M_AXI_BVALID  & M_AXI_BREADY;
  assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs  = M_AXI_RVALID  & M_AXI_RREADY;
  // to_cnt holds busy cycles already completed, so hitting TIMEOUT_CYCLES-1 means this is the last one
  assign timed_out = TO_EN && (state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP}) && (to_cnt == TO_LIM);

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = '1;
  assign rsp_write    = write_q;

  always_comb begin
    state_n       = state;
    to_cnt_n      = to_cnt;
    aw_done_n     = aw_done;
    w_done_n      = w_done;
    addr_n        = addr_q;
    wdata_n       = wdata_q;
    write_n       = write_q;
    rsp_resp_n    = rsp_resp;
    rsp_rdata_n   = rsp_rdata;
    rsp_timeout_n = rsp_timeout;
    if (state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP}) to_cnt_n = to_cnt + CW'(1);
    case (state)
      IDLE: if (cmd_valid && cmd_ready) begin
        state_n   = cmd_write ? WR_REQ : RD_REQ;
        addr_n    = cmd_addr;
        wdata_n   = cmd_wdata;
        write_n   = cmd_write;
        to_cnt_n  = '0;
        aw_done_n = 1'b0;
        w_done_n  = 1'b0;
      end
      WR_REQ: begin
        if (aw_hs) aw_done_n = 1'b1;
        if (w_hs)  w_done_n  = 1'b1;
        if (aw_done_n && w_done_n) state_n = WR_RESP;
      end
      WR_RESP: if (b_hs) begin
        state_n       = RESP;
        rsp_resp_n    = M_AXI_BRESP;
        rsp_rdata_n   = '0;
        rsp_timeout_n = 1'b0;
      end
      RD_REQ: if (ar_hs) state_n = RD_RESP;
      RD_RESP: if (r_hs) begin
        state_n       = RESP;
        rsp_resp_n    = M_AXI_RRESP;
        rsp_rdata_n   = M_AXI_RDATA;
        rsp_timeout_n = 1'b0;
      end
      RESP: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // A B/R beat accepted in the final cycle is a real completion, not a timeout
    if (timed_out && !(b_hs || r_hs)) begin
      state_n       = RESP;
      rsp_resp_n    = RESP_SLVERR;
      rsp_rdata_n   = '0;
      rsp_timeout_n = 1'b1;
    end
    cmd_ready_n = (state_n == IDLE);
    busy_n      = (state_n != IDLE);
    rsp_valid_n = (state_n == RESP);
    awvalid_n   = (state_n == WR_REQ) && !aw_done_n;
    wvalid_n    = (state_n == WR_REQ) && !w_done_n;
    bready_n    = (state_n == WR_RESP);
    arvalid_n   = (state_n == RD_REQ);
    rready_n    = (state_n == RD_RESP);
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state         <= IDLE;
      to_cnt        <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      rsp_resp      <= '0;
      rsp_rdata     <= '0;
      rsp_timeout   <= 1'b0;
      cmd_ready     <= 1'b0;
      busy          <= 1'b0;
      rsp_valid     <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      state         <= state_n;
      to_cnt        <= to_cnt_n;
      aw_done       <= aw_done_n;
      w_done        <= w_done_n;
      addr_q        <= addr_n;
      wdata_q       <= wdata_n;
      write_q       <= write_n;
      rsp_resp      <= rsp_resp_n;
      rsp_rdata     <= rsp_rdata_n;
      rsp_timeout   <= rsp_timeout_n;
      cmd_ready     <= cmd_ready_n;
      busy          <= busy_n;
      rsp_valid     <= rsp_valid_n;
      M_AXI_AWVALID <= awvalid_n;
      M_AXI_WVALID  <= wvalid_n;
      M_AXI_BREADY  <= bready_n;
      M_AXI_ARVALID <= arvalid_n;
      M_AXI_RREADY  <= rready_n;
    end
  end

endmodule

// File: tb/tb_dfr_axi_lite_master.sv
// Directed bench for dfr_axi_lite_master with a small behavioural AXI4-Lite slave.
module tb_dfr_axi_lite_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [29:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic cmd_ready, rsp_valid, rsp_write, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [29:0] awaddr, araddr;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0] bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dfr_axi_lite_master #(
    .C_M_AXI_ADDR_WIDTH(30),
    .C_M_AXI_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // Slave model: handshakes recorded on the rising edge, responses driven on the falling edge
  logic [31:0] mem [logic [29:0]];
  int aw_delay = 0, w_delay = 0, aw_wait = 0, w_wait = 0;
  bit ar_en = 1'b1;
  bit aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
  logic [29:0] s_awaddr = '0;
  logic [31:0] s_wdata = '0, s_rdata = '0;
  int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0;

  always @(posedge clk) begin
    if (rst) begin
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    end else begin
      if (awvalid && awready) begin aw_got = 1; s_awaddr = awaddr; aw_hs_n++; end
      if (wvalid && wready) begin w_got = 1; s_wdata = wdata; w_hs_n++; end
      if (bvalid && bready) begin b_pend = 0; b_hs_n++; end
      if (aw_got && w_got) begin mem[s_awaddr] = s_wdata; aw_got = 0; w_got = 0; b_pend = 1; end
      if (rvalid && rready) r_pend = 0;
      if (arvalid && arready) begin
        ar_hs_n++;
        r_pend = 1;
        s_rdata = mem.exists(araddr) ? mem[araddr] : 32'h0;
      end
    end
  end

  always @(negedge clk) begin
    if (awvalid) begin awready = (aw_wait >= aw_delay); aw_wait++; end
    else begin awready = 1'b0; aw_wait = 0; end
    if (wvalid) begin wready = (w_wait >= w_delay); w_wait++; end
    else begin wready = 1'b0; w_wait = 0; end
    bvalid  = b_pend;
    arready = arvalid && ar_en;
    rvalid  = r_pend;
    rdata   = r_pend ? s_rdata : 32'h0;
  end

  task automatic send_cmd(input logic wr, input logic [29:0] a, input logic [31:0] d);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int start, output bit ok, output int cyc);
    cyc = start;
    while (!rsp_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
    ok = rsp_valid;
  endtask

  task automatic take_rsp;
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({cmd_ready, busy, rsp_valid, awvalid, wvalid, bready, arvalid, rready, rsp_timeout} !== 9'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 000000000",
        {cmd_ready, busy, rsp_valid, awvalid, wvalid, bready, arvalid, rready, rsp_timeout});
    end
    checks++;
    if ({awaddr, wdata, rsp_rdata, rsp_resp} !== '0) begin
      errors++; $display("FAIL reset_data: awaddr=%h wdata=%h rdata=%h resp=%b want 0", awaddr, wdata, rsp_rdata, rsp_resp);
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_release_ready: got %b want 0", cmd_ready); end
    @(posedge clk); #1;
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin errors++; $display("FAIL reset_first_cycle: ready,busy=%b want 10", {cmd_ready, busy}); end
  endtask

  task automatic test_write_zero_wait;
    send_cmd(1'b1, 30'h14, 32'h64);
    checks++;
    if ({awvalid, wvalid, cmd_ready, busy} !== 4'b1101) begin
      errors++; $display("FAIL wr_c1_ctrl: aw,w,ready,busy=%b want 1101", {awvalid, wvalid, cmd_ready, busy});
    end
    checks++;
    if (awaddr !== 30'h14 || wdata !== 32'h64 || wstrb !== 4'hF) begin
      errors++; $display("FAIL wr_c1_data: awaddr=%h wdata=%h wstrb=%h want 14 64 f", awaddr, wdata, wstrb);
    end
    @(posedge clk); #1;
    checks++;
    if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010) begin
      errors++; $display("FAIL wr_c2: aw,w,bready,rsp_valid=%b want 0010", {awvalid, wvalid, bready, rsp_valid});
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_write, rsp_timeout, bready} !== 4'b1100 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL wr_c3_rsp: valid,write,to,bready=%b resp=%b rdata=%h want 1100 00 0",
        {rsp_valid, rsp_write, rsp_timeout, bready}, rsp_resp, rsp_rdata);
    end
    take_rsp();
    checks++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
      errors++; $display("FAIL wr_taken: valid,ready,busy=%b want 010", {rsp_valid, cmd_ready, busy});
    end
    checks++;
    if (mem[30'h14] !== 32'h64) begin errors++; $display("FAIL wr_slave_mem: got %h want 64", mem[30'h14]); end
  endtask

  task automatic test_skewed_write;
    int aw0, w0, b0, cyc;
    bit ok;
    aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
    w_delay = 3;
    send_cmd(1'b1, 30'h0, 32'hA5);
    checks++;
    if ({awvalid, wvalid} !== 2'b11) begin errors++; $display("FAIL skew_c1: aw,w=%b want 11", {awvalid, wvalid}); end
    @(posedge clk); #1;
    checks++;
    if ({awvalid, wvalid} !== 2'b01) begin errors++; $display("FAIL skew_c2: aw,w=%b want 01", {awvalid, wvalid}); end
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({awvalid, wvalid, bready} !== 3'b010) begin errors++; $display("FAIL skew_c4: aw,w,bready=%b want 010", {awvalid, wvalid, bready}); end
    wait_rsp(4, ok, cyc);
    checks++;
    if (!ok || cyc != 6) begin errors++; $display("FAIL skew_latency: ok=%0d cycle=%0d want 1 6", ok, cyc); end
    checks++;
    if (rsp_resp !== 2'b00 || rsp_write !== 1'b1) begin errors++; $display("FAIL skew_rsp: resp=%b write=%b want 00 1", rsp_resp, rsp_write); end
    take_rsp();
    repeat (3) @(posedge clk); #1;
    checks++;
    if (aw_hs_n - aw0 != 1 || w_hs_n - w0 != 1 || b_hs_n - b0 != 1) begin
      errors++; $display("FAIL skew_hs_count: aw=%0d w=%0d b=%0d want 1 1 1", aw_hs_n - aw0, w_hs_n - w0, b_hs_n - b0);
    end
    w_delay = 0;
  endtask

  task automatic test_read_after_write;
    int cyc;
    bit ok;
    send_cmd(1'b1, 30'h0100_0004, 32'd300);
    wait_rsp(1, ok, cyc);
    checks++;
    if (!ok || rsp_resp !== 2'b00) begin errors++; $display("FAIL raw_write: ok=%0d resp=%b want 1 00", ok, rsp_resp); end
    take_rsp();
    send_cmd(1'b0, 30'h0100_0004, 32'h0);
    checks++;
    if ({arvalid, cmd_ready} !== 2'b10 || araddr !== 30'h0100_0004) begin
      errors++; $display("FAIL raw_c1: arvalid,ready=%b araddr=%h want 10 1000004", {arvalid, cmd_ready}, araddr);
    end
    @(posedge clk); #1;
    checks++;
    if ({arvalid, rready, cmd_ready} !== 3'b010) begin
      errors++; $display("FAIL raw_c2: arvalid,rready,ready=%b want 010", {arvalid, rready, cmd_ready});
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_write, cmd_ready, rsp_timeout} !== 4'b1000 || rsp_rdata !== 32'h12C || rsp_resp !== 2'b00) begin
      errors++; $display("FAIL raw_c3: valid,write,ready,to=%b rdata=%h resp=%b want 1000 12c 00",
        {rsp_valid, rsp_write, cmd_ready, rsp_timeout}, rsp_rdata, rsp_resp);
    end
    take_rsp();
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL raw_ready_after: got %b want 1", cmd_ready); end
  endtask

  task automatic test_backpressure;
    int cyc;
    bit ok;
    mem[30'h20] = 32'hDEAD_BEEF;
    send_cmd(1'b0, 30'h20, 32'h0);
    wait_rsp(1, ok, cyc);
    checks++;
    if (!ok || cyc != 3) begin errors++; $display("FAIL bp_rsp_arrive: ok=%0d cycle=%0d want 1 3", ok, cyc); end
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 30'h4; cmd_wdata = 32'h1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_write, rsp_timeout, cmd_ready, awvalid, arvalid, busy} !== 7'b1000001) begin
        errors++; $display("FAIL bp_hold_ctrl[%0d]: got %b want 1000001", i,
          {rsp_valid, rsp_write, rsp_timeout, cmd_ready, awvalid, arvalid, busy});
      end
      checks++;
      if (rsp_rdata !== 32'hDEAD_BEEF || rsp_resp !== 2'b00) begin
        errors++; $display("FAIL bp_hold_data[%0d]: rdata=%h resp=%b want deadbeef 00", i, rsp_rdata, rsp_resp);
      end
    end
    @(negedge clk); cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready, busy, awvalid} !== 4'b0100) begin
      errors++; $display("FAIL bp_taken: valid,ready,busy,awvalid=%b want 0100", {rsp_valid, cmd_ready, busy, awvalid});
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, awvalid} !== 2'b00) begin errors++; $display("FAIL bp_no_late_accept: busy,awvalid=%b want 00", {busy, awvalid}); end
  endtask

  task automatic test_timeout;
    int n, ar0;
    ar0 = ar_hs_n;
    ar_en = 1'b0;
    send_cmd(1'b0, 30'h8, 32'h0);
    n = 0;
    while (arvalid && n < 40) begin n++; @(posedge clk); #1; end
    checks++;
    if (n != 16) begin errors++; $display("FAIL to_arvalid_cycles: got %0d want 16", n); end
    checks++;
    if ({rsp_valid, rsp_timeout, rsp_write, rready, arvalid, busy} !== 6'b110001) begin
      errors++; $display("FAIL to_rsp_ctrl: valid,to,write,rready,arvalid,busy=%b want 110001",
        {rsp_valid, rsp_timeout, rsp_write, rready, arvalid, busy});
    end
    checks++;
    if (rsp_resp !== 2'b10 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL to_rsp_data: resp=%b rdata=%h want 10 0", rsp_resp, rsp_rdata);
    end
    take_rsp();
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01 || ar_hs_n != ar0) begin
      errors++; $display("FAIL to_recover: valid,ready=%b ar_hs=%0d want 01 0", {rsp_valid, cmd_ready}, ar_hs_n - ar0);
    end
    ar_en = 1'b1;
  endtask

  task automatic test_reset_mid_write;
    int cyc;
    bit ok;
    aw_delay = 5;
    send_cmd(1'b1, 30'h18, 32'h55);
    @(posedge clk); #1;
    checks++;
    if ({awvalid, busy} !== 2'b11) begin errors++; $display("FAIL rst_pre: awvalid,busy=%b want 11", {awvalid, busy}); end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, busy, cmd_ready, rsp_valid} !== 8'b0) begin
      errors++; $display("FAIL rst_async: got %b want 00000000",
        {awvalid, wvalid, bready, arvalid, rready, busy, cmd_ready, rsp_valid});
    end
    aw_delay = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_back: got %b want 1", cmd_ready); end
    send_cmd(1'b0, 30'h0, 32'h0);
    wait_rsp(1, ok, cyc);
    checks++;
    if (!ok || cyc != 3) begin errors++; $display("FAIL rst_read_latency: ok=%0d cycle=%0d want 1 3", ok, cyc); end
    checks++;
    if (rsp_rdata !== 32'hA5 || rsp_resp !== 2'b00 || {rsp_timeout, rsp_write} !== 2'b00) begin
      errors++; $display("FAIL rst_read_rsp: rdata=%h resp=%b to,write=%b want a5 00 00",
        rsp_rdata, rsp_resp, {rsp_timeout, rsp_write});
    end
    take_rsp();
    checks++;
    if (mem.exists(30'h18)) begin errors++; $display("FAIL rst_no_write: aborted write reached slave"); end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_skewed_write();
    test_read_after_write();
    test_backpressure();
    test_timeout();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
